// File: rtl/operand_forward_unit_if.sv
// Decode-side bundle for the operand forwarding unit. The decode stage
// drives the instruction fields and pipeline controls. The forwarding
// unit returns the operand mux selects, the decode stall and the
// load-use stall count.
interface operand_forward_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  flush;
    logic                  pipe_hold;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic                  stall_id;
    logic [CNT_W-1:0]      load_use_stalls;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_mem_read, flush, pipe_hold,
        input  fwd_a_sel, fwd_b_sel, stall_id, load_use_stalls
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_mem_read, flush, pipe_hold,
        output fwd_a_sel, fwd_b_sel, stall_id, load_use_stalls
    );
endinterface

// File: rtl/operand_forward_unit.sv
// Operand forwarding and load-use hazard unit for a 5-stage RV32I pipeline.
// The unit tracks the destination registers of the EX, MEM and WB stages.
// It registers the ALU operand mux selects into EX, one cycle after decode.
// Select codes: 00 register file, 01 MEM/WB writeback, 10 EX/MEM ALU result.
module operand_forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    operand_forward_unit_if.slave bus
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_t;

    typedef enum logic [1:0] {
        SEL_RF = 2'b00,
        SEL_WB = 2'b01,
        SEL_EX = 2'b10
    } fwd_sel_e;

    stage_t           ex_q, mem_q, wb_q;
    fwd_sel_e         sel_a_q, sel_b_q;
    logic [CNT_W-1:0] stalls_q;

    logic     hz_a, hz_b, stall, bubble;
    fwd_sel_e code_a, code_b;

    // A used, non-zero source that matches a load still in EX cannot be served yet.
    function automatic logic load_hazard(input logic [REG_ADDR_W-1:0] rs,
                                         input logic used, input stage_t ex);
        return used && (rs != '0) && ex.valid && ex.mem_read && (ex.rd == rs);
    endfunction

    // The newest producer wins. A load in EX never gives 10 because its data is not ready.
    function automatic fwd_sel_e fwd_code(input logic [REG_ADDR_W-1:0] rs,
                                          input logic used,
                                          input stage_t ex, input stage_t mem);
        fwd_sel_e code;
        code = SEL_RF;
        if (used && (rs != '0)) begin
            if (ex.valid && ex.reg_write && !ex.mem_read && (ex.rd == rs))
                code = SEL_EX;
            else if (mem.valid && mem.reg_write && (mem.rd == rs))
                code = SEL_WB;
        end
        return code;
    endfunction

    // Hazard detection, bubble decision and next-cycle select codes for the decode instruction.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        hz_a   = 1'b0;
        hz_b   = 1'b0;
        code_a = SEL_RF;
        code_b = SEL_RF;
        if (bus.id_valid) begin
            hz_a = load_hazard(bus.id_rs1, bus.id_rs1_used, ex_q);
            hz_b = load_hazard(bus.id_rs2, bus.id_rs2_used, ex_q);
        end
        code_a = fwd_code(bus.id_rs1, bus.id_rs1_used, ex_q, mem_q);
        code_b = fwd_code(bus.id_rs2, bus.id_rs2_used, ex_q, mem_q);
        stall  = (hz_a | hz_b) & ~bus.flush;
        bubble = bus.flush | stall | ~bus.id_valid;
    end

    // Advance the stage entries, register the selects and count stall cycles unless frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            sel_a_q  <= SEL_RF;
            sel_b_q  <= SEL_RF;
            stalls_q <= '0;
        end else if (!bus.pipe_hold) begin
            // NOTE: non-blocking updates let mem_q take the old ex_q and wb_q take the old mem_q on the same edge.
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (bubble) begin
                ex_q    <= '0;
                sel_a_q <= SEL_RF;
                sel_b_q <= SEL_RF;
            end else begin
                ex_q    <= '{valid: 1'b1, rd: bus.id_rd,
                             reg_write: bus.id_reg_write, mem_read: bus.id_mem_read};
                sel_a_q <= code_a;
                sel_b_q <= code_b;
            end
            if (stall && (stalls_q != '1))
                stalls_q <= stalls_q + 1'b1;
        end
    end

    assign bus.fwd_a_sel       = sel_a_q;
    assign bus.fwd_b_sel       = sel_b_q;
    assign bus.stall_id        = stall;
    assign bus.load_use_stalls = stalls_q;

    // The WB entry always trails MEM by exactly one advancing clock.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !bus.pipe_hold |=> (wb_q == $past(mem_q)));

endmodule
